// File: rtl/seg_scan_decoder.sv
// Receive side of a multiplexed active-low 7-segment display: filters the scanned
// anode/segment stream, recovers four BCD digits, and flags malformed scans.
module seg_scan_decoder #(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned FRAME_TIMEOUT = 1048576
) (
    input  logic        clk_100MHz,
    input  logic        reset,
    input  logic [3:0]  anode_in,
    input  logic [6:0]  seg_in,
    output logic [15:0] value_out,
    output logic        frame_valid,
    output logic        locked,
    output logic        err_sequence,
    output logic        err_timeout,
    output logic        err_pattern
);

    localparam int unsigned TW = $clog2(FRAME_TIMEOUT + 1);
    localparam logic [7:0]    STABLE_MAX = 8'(STABLE_CYCLES);
    localparam logic [7:0]    ACCEPT_AT  = 8'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(FRAME_TIMEOUT - 1);

    typedef enum logic {HUNT, COLLECT} state_t;

    state_t            state, state_n;
    logic [10:0]       sample;
    logic [7:0]        stable_cnt;
    logic [TW-1:0]     timer, timer_n;
    logic [1:0]        exp_idx, exp_n, last_idx, last_n;
    logic [3:0][3:0]   digits, digits_n;
    logic [15:0]       value_n;
    logic              locked_n, fv_n, es_n, et_n, ep_n;
    logic [3:0]        anode;
    logic [6:0]        seg;
    logic [1:0]        anode_idx;
    logic              anode_ok, accept, hunt_take;
    logic [3:0]        nib;
    logic              bad_code;

    assign anode = sample[10:7];
    assign seg   = sample[6:0];

    // The new sample is compared against the one it replaces, so the count restarts on the same edge
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            sample     <= 11'h7FF;
            stable_cnt <= '0;
        end else begin
            sample <= {anode_in, seg_in};
            if ({anode_in, seg_in} != sample)
                stable_cnt <= '0;
            else if (stable_cnt != STABLE_MAX)
                stable_cnt <= stable_cnt + 8'd1;
        end
    end

    always_comb begin
        anode_ok  = 1'b1;
        anode_idx = 2'd0;
        case (anode)
            4'b0111: anode_idx = 2'd3;
            4'b1011: anode_idx = 2'd2;
            4'b1101: anode_idx = 2'd1;
            4'b1110: anode_idx = 2'd0;
            default: anode_ok  = 1'b0;
        endcase
    end

    assign accept = anode_ok && (stable_cnt == ACCEPT_AT);

    always_comb begin
        bad_code = 1'b0;
        nib      = 4'hE;
        case (seg)
            7'b0000001: nib = 4'h0;
            7'b1001111: nib = 4'h1;
            7'b0010010: nib = 4'h2;
            7'b0000110: nib = 4'h3;
            7'b1001100: nib = 4'h4;
            7'b0100100: nib = 4'h5;
            7'b0100000: nib = 4'h6;
            7'b0001111: nib = 4'h7;
            7'b0000000: nib = 4'h8;
            7'b0000100: nib = 4'h9;
            7'b1111111: nib = 4'hF;
            default:    bad_code = 1'b1;
        endcase
    end

    always_comb begin
        state_n   = state;
        timer_n   = timer;
        exp_n     = exp_idx;
        last_n    = last_idx;
        digits_n  = digits;
        value_n   = value_out;
        locked_n  = locked;
        fv_n      = 1'b0;
        es_n      = 1'b0;
        et_n      = 1'b0;
        ep_n      = 1'b0;
        hunt_take = 1'b0;
        if (accept) begin
            ep_n    = bad_code;
            timer_n = '0;
            if (state == HUNT) begin
                hunt_take = (anode_idx == 2'd3);
            end else if (anode_idx == last_idx) begin
                digits_n[anode_idx] = nib;
            end else if (anode_idx == exp_idx) begin
                digits_n[anode_idx] = nib;
                last_n              = anode_idx;
                if (anode_idx == 2'd0) begin
                    value_n  = digits_n;
                    fv_n     = 1'b1;
                    locked_n = 1'b1;
                    exp_n    = 2'd3;
                end else begin
                    exp_n = exp_idx - 2'd1;
                end
            end else begin
                es_n      = 1'b1;
                locked_n  = 1'b0;
                state_n   = HUNT;
                hunt_take = (anode_idx == 2'd3);
            end
            // A digit-3 accept restarts the frame, including right after a sequence error
            if (hunt_take) begin
                digits_n[3] = nib;
                exp_n       = 2'd2;
                last_n      = 2'd3;
                state_n     = COLLECT;
            end
        end else if (state == COLLECT) begin
            if (timer == TIMER_LAST) begin
                et_n     = 1'b1;
                locked_n = 1'b0;
                state_n  = HUNT;
                timer_n  = '0;
            end else begin
                timer_n = timer + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state        <= HUNT;
            timer        <= '0;
            exp_idx      <= 2'd3;
            last_idx     <= 2'd3;
            digits       <= '1;
            value_out    <= 16'hFFFF;
            locked       <= 1'b0;
            frame_valid  <= 1'b0;
            err_sequence <= 1'b0;
            err_timeout  <= 1'b0;
            err_pattern  <= 1'b0;
        end else begin
            state        <= state_n;
            timer        <= timer_n;
            exp_idx      <= exp_n;
            last_idx     <= last_n;
            digits       <= digits_n;
            value_out    <= value_n;
            locked       <= locked_n;
            frame_valid  <= fv_n;
            err_sequence <= es_n;
            err_timeout  <= et_n;
            err_pattern  <= ep_n;
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed scans plus random hold sequences checked
// every cycle against a hold-length/protocol reference model.
module tb_seg_scan_decoder;

    localparam int unsigned S  = 16;
    localparam int unsigned FT = 1000;

    logic        clk_100MHz = 1'b0;
    logic        reset      = 1'b0;
    logic [3:0]  anode_in   = 4'hF;
    logic [6:0]  seg_in     = 7'h7F;
    logic [15:0] value_out;
    logic        frame_valid, locked, err_sequence, err_timeout, err_pattern;

    always #5 clk_100MHz = ~clk_100MHz;

    seg_scan_decoder #(.STABLE_CYCLES(S), .FRAME_TIMEOUT(FT)) dut (
        .clk_100MHz  (clk_100MHz),
        .reset       (reset),
        .anode_in    (anode_in),
        .seg_in      (seg_in),
        .value_out   (value_out),
        .frame_valid (frame_valid),
        .locked      (locked),
        .err_sequence(err_sequence),
        .err_timeout (err_timeout),
        .err_pattern (err_pattern)
    );

    int checks = 0, errors = 0;
    int cyc = 0, last_acc_cyc = 0, et_cyc = 0;
    int fv_seen = 0, es_seen = 0, et_seen = 0, ep_seen = 0;
    int fv_seen_total = 0, fv_model_total = 0;

    bit          m_collect;
    int          m_exp, m_last, m_timer;
    logic [3:0]  m_dig [4];
    logic [15:0] m_value;
    bit          m_locked, m_fv, m_es, m_et, m_ep;
    logic [10:0] prev_pat = 11'h7FF;

    logic [6:0] codes [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                               7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] decode(input logic [6:0] c);
        if (c == 7'h7F) return {1'b0, 4'hF};
        for (int k = 0; k < 10; k++)
            if (codes[k] == c) return {1'b0, 4'(k)};
        return {1'b1, 4'hE};
    endfunction

    task automatic start_frame(input logic [3:0] nib);
        m_dig[3]  = nib;
        m_exp     = 2;
        m_last    = 3;
        m_collect = 1;
    endtask

    task automatic model_accept(input int idx, input logic [6:0] code);
        logic [4:0] d;
        d       = decode(code);
        m_ep    = d[4];
        m_timer = 0;
        if (!m_collect) begin
            if (idx == 3) start_frame(d[3:0]);
        end else if (idx == m_last) begin
            m_dig[idx] = d[3:0];
        end else if (idx == m_exp) begin
            m_dig[idx] = d[3:0];
            m_last     = idx;
            if (idx == 0) begin
                m_value  = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
                m_fv     = 1;
                m_locked = 1;
                m_exp    = 3;
                fv_model_total++;
            end else begin
                m_exp = m_exp - 1;
            end
        end else begin
            m_es      = 1;
            m_locked  = 0;
            m_collect = 0;
            if (idx == 3) start_frame(d[3:0]);
        end
    endtask

    task automatic edge_step(input bit acc, input int idx, input logic [6:0] code, input bit rst);
        @(posedge clk_100MHz);
        cyc++;
        m_fv = 0; m_es = 0; m_et = 0; m_ep = 0;
        if (rst) begin
            m_collect = 0; m_exp = 3; m_last = 3; m_timer = 0;
            for (int k = 0; k < 4; k++) m_dig[k] = 4'hF;
            m_value  = 16'hFFFF;
            m_locked = 0;
        end else if (acc) begin
            model_accept(idx, code);
            last_acc_cyc = cyc;
        end else if (m_collect) begin
            m_timer++;
            if (m_timer == int'(FT)) begin
                m_et = 1; m_locked = 0; m_collect = 0; m_timer = 0;
            end
        end
        #1;
        check("outputs",
              32'({value_out, frame_valid, locked, err_sequence, err_timeout, err_pattern}),
              32'({m_value, m_fv, m_locked, m_es, m_et, m_ep}));
        if (frame_valid) begin fv_seen++; fv_seen_total++; end
        if (err_sequence) es_seen++;
        if (err_timeout) begin et_seen++; et_cyc = cyc; end
        if (err_pattern) ep_seen++;
    endtask

    task automatic do_reset();
        anode_in = 4'hF;
        seg_in   = 7'h7F;
        reset    = 1'b1;
        edge_step(0, 0, 7'h7F, 1);
        reset    = 1'b0;
        prev_pat = 11'h7FF;
    endtask

    // A hold merges with the previous one if identical, so such holds are skipped
    task automatic hold(input logic [3:0] an, input logic [6:0] sg, input int unsigned len);
        logic [3:0] na;
        bit ok;
        int idx;
        na  = ~an;
        ok  = ($countones(na) == 1) && (len > S);
        idx = 0;
        for (int b = 0; b < 4; b++) if (na[b]) idx = b;
        if ({an, sg} == prev_pat || len == 0) return;
        for (int unsigned i = 0; i < len; i++) begin
            anode_in = an;
            seg_in   = sg;
            edge_step(ok && (i == S), idx, sg, 0);
        end
        prev_pat = {an, sg};
    endtask

    task automatic scan(input logic [6:0] c3, input logic [6:0] c2, input logic [6:0] c1, input logic [6:0] c0);
        hold(4'b0111, c3, 20);
        hold(4'b1011, c2, 20);
        hold(4'b1101, c1, 20);
        hold(4'b1110, c0, 20);
    endtask

    task automatic clear_tally();
        fv_seen = 0; es_seen = 0; et_seen = 0; ep_seen = 0;
    endtask

    initial begin
        int unsigned rr, r, len, sel;
        logic [3:0] an;
        logic [6:0] sg;

        do_reset();
        check("reset_value", 32'(value_out), 32'h0000FFFF);
        check("reset_locked", 32'(locked), 32'd0);

        // 1: clean frame 0123
        clear_tally();
        scan(codes[0], codes[1], codes[2], codes[3]);
        check("t1_value", 32'(value_out), 32'h00000123);
        check("t1_locked", 32'(locked), 32'd1);
        check("t1_fv_count", 32'(fv_seen), 32'd1);
        check("t1_err_count", 32'(es_seen + et_seen + ep_seen), 32'd0);

        // 2: short glitch between digits must not accept
        clear_tally();
        hold(4'b0111, codes[0], 20);
        hold(4'b1011, 7'b0100100, 5);
        hold(4'b1011, codes[1], 20);
        hold(4'b1101, codes[2], 20);
        hold(4'b1110, codes[3], 20);
        check("t2_value", 32'(value_out), 32'h00000123);
        check("t2_fv_count", 32'(fv_seen), 32'd1);
        check("t2_seq_count", 32'(es_seen), 32'd0);

        // 3: skipped digit
        clear_tally();
        hold(4'b0111, codes[0], 20);
        hold(4'b1101, codes[2], 20);
        check("t3_seq_count", 32'(es_seen), 32'd1);
        check("t3_unlocked", 32'(locked), 32'd0);
        scan(codes[0], codes[1], codes[2], codes[3]);
        check("t3_value", 32'(value_out), 32'h00000123);
        check("t3_relocked", 32'(locked), 32'd1);

        // 4: timeout after digit 2
        clear_tally();
        hold(4'b0111, codes[4], 20);
        hold(4'b1011, codes[5], 20);
        hold(4'hF, 7'h7F, 1100);
        check("t4_to_count", 32'(et_seen), 32'd1);
        check("t4_latency", 32'(et_cyc - last_acc_cyc), 32'(FT));
        check("t4_unlocked", 32'(locked), 32'd0);
        check("t4_value", 32'(value_out), 32'h00000123);

        // 5: blank and unknown pattern
        clear_tally();
        scan(7'h7F, codes[1], 7'b1111110, codes[3]);
        check("t5_pat_count", 32'(ep_seen), 32'd1);
        check("t5_value", 32'(value_out), 32'h0000F1E3);

        // 6: reset mid-frame
        clear_tally();
        hold(4'b0111, codes[4], 20);
        hold(4'b1011, codes[5], 20);
        do_reset();
        check("t6_reset_value", 32'(value_out), 32'h0000FFFF);
        check("t6_reset_locked", 32'(locked), 32'd0);
        clear_tally();
        scan(codes[4], codes[5], codes[6], codes[7]);
        check("t6_value", 32'(value_out), 32'h00004567);
        check("t6_fv_count", 32'(fv_seen), 32'd1);

        // Random holds: mostly in-order scans with glitches, idles, stray digits and bad codes
        rr = 3;
        for (int n = 0; n < 500; n++) begin
            r = $urandom_range(0, 11);
            if ($urandom_range(0, 79) == 0) begin
                do_reset();
                continue;
            end
            case (r)
                0: begin
                    an  = 4'hF;
                    sg  = 7'($urandom);
                    len = ($urandom_range(0, 24) == 0) ? 1100 : $urandom_range(1, 40);
                end
                1: begin
                    an = 4'($urandom);
                    if ($countones(~an) <= 1) an = 4'b0011;
                    sg  = 7'($urandom);
                    len = $urandom_range(1, 40);
                end
                2: begin
                    an  = ~(4'b0001 << $urandom_range(0, 3));
                    sg  = codes[$urandom_range(0, 9)];
                    len = $urandom_range(1, S - 1);
                end
                3: begin
                    an  = ~(4'b0001 << $urandom_range(0, 3));
                    sg  = codes[$urandom_range(0, 9)];
                    len = $urandom_range(S + 1, S + 8);
                end
                default: begin
                    an  = ~(4'b0001 << rr);
                    sel = $urandom_range(0, 11);
                    sg  = (sel < 10) ? codes[sel] : ((sel == 10) ? 7'h7F : 7'($urandom));
                    len = $urandom_range(S + 1, S + 8);
                    rr  = (rr == 0) ? 3 : rr - 1;
                end
            endcase
            hold(an, sg, len);
        end
        check("fv_total", 32'(fv_seen_total), 32'(fv_model_total));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
